// File: rtl/sha_digest_tx.sv
// sha_digest_tx - serialises SHA digest results into a valid/ready byte stream.
//
// A digest arrives as a one-cycle ivalid pulse carrying {iid, ilen, isha}. The
// core cannot be stalled, so entries go into a small FIFO. The head entry is
// then sent as a frame of bytes with tvalid/tready/tlast, and tid/tlen held
// constant for the whole frame. The head stays in the FIFO until its last byte
// handshakes, so the FIFO holds 2**FIFO_AW digests including the one in flight.
//
// Optional build macro: SHA_DIGEST_TX_HEX_EN
//   undefined : raw frames, DIGEST_BYTES bytes, most significant byte first
//   defined   : lowercase ASCII hex, high nibble first, then 0x0A carrying tlast
//               (2*DIGEST_BYTES+1 bytes per frame)
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   ivalid/iid/ilen/isha  digest input, no backpressure
//   tvalid/tready/tlast/tdata  byte stream output
//   tid/tlen           id and length of the frame being sent
//   ovf                sticky flag, set when a digest is dropped on a full FIFO
module sha_digest_tx #(
  parameter int DIGEST_BYTES = 48,
  parameter int FIFO_AW      = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      ivalid,
  input  logic [31:0]               iid,
  input  logic [60:0]               ilen,
  input  logic [DIGEST_BYTES*8-1:0] isha,
  output logic                      tvalid,
  input  logic                      tready,
  output logic                      tlast,
  output logic [31:0]               tid,
  output logic [60:0]               tlen,
  output logic [7:0]                tdata,
  output logic                      ovf
);

  localparam int DW    = DIGEST_BYTES * 8;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int PW    = FIFO_AW + 1;
`ifdef SHA_DIGEST_TX_HEX_EN
  localparam int FRAME_LEN = 2 * DIGEST_BYTES + 1;
`else
  localparam int FRAME_LEN = DIGEST_BYTES;
`endif
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Byte k of the frame built from digest d.
  function automatic logic [7:0] frame_byte(input logic [DW-1:0] d, input logic [CW-1:0] k);
    logic [DW-1:0] v_sh;
`ifdef SHA_DIGEST_TX_HEX_EN
    logic [3:0] v_nib;
    v_sh  = d << {k, 2'b00};
    v_nib = v_sh[DW-1 -: 4];
    if (k == LAST_IDX) begin
      frame_byte = 8'h0A;
    end else if (v_nib < 4'd10) begin
      frame_byte = 8'h30 + {4'h0, v_nib};
    end else begin
      // 'a' (0x61) minus 10
      frame_byte = 8'h57 + {4'h0, v_nib};
    end
`else
    v_sh       = d << {k, 3'b000};
    frame_byte = v_sh[DW-1 -: 8];
`endif
  endfunction

  logic [31:0]   r_mem_id  [DEPTH];
  logic [60:0]   r_mem_len [DEPTH];
  logic [DW-1:0] r_mem_sha [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic          r_ovf;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          r_tvalid, w_tvalid_nxt;
  logic          r_tlast, w_tlast_nxt;
  logic [7:0]    r_tdata, w_tdata_nxt;
  logic [31:0]   r_tid, w_tid_nxt;
  logic [60:0]   r_tlen, w_tlen_nxt;

  logic          w_full, w_empty, w_push, w_pop;
  logic [31:0]   w_head_id;
  logic [60:0]   w_head_len;
  logic [DW-1:0] w_head_sha;

  // Full is judged before any same-edge pop, so a pop never makes room for a push.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                      (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign w_push     = ivalid & ~w_full;
  assign w_head_id  = r_mem_id[r_rd_ptr[FIFO_AW-1:0]];
  assign w_head_len = r_mem_len[r_rd_ptr[FIFO_AW-1:0]];
  assign w_head_sha = r_mem_sha[r_rd_ptr[FIFO_AW-1:0]];
  assign w_cnt_inc  = r_cnt + CW'(1);

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_id[r_wr_ptr[FIFO_AW-1:0]]  <= iid;
      r_mem_len[r_wr_ptr[FIFO_AW-1:0]] <= ilen;
      r_mem_sha[r_wr_ptr[FIFO_AW-1:0]] <= isha;
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (ivalid && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // FSM state and registered stream outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= 8'h00;
      r_tid    <= 32'h0;
      r_tlen   <= 61'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_tlast  <= w_tlast_nxt;
      r_tdata  <= w_tdata_nxt;
      r_tid    <= w_tid_nxt;
      r_tlen   <= w_tlen_nxt;
    end
  end

  // Next-state and next-output logic; outputs hold unless a handshake or load occurs.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_tvalid_nxt = r_tvalid;
    w_tlast_nxt  = r_tlast;
    w_tdata_nxt  = r_tdata;
    w_tid_nxt    = r_tid;
    w_tlen_nxt   = r_tlen;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt  = ST_SEND;
          w_cnt_nxt    = {CW{1'b0}};
          w_tvalid_nxt = 1'b1;
          w_tlast_nxt  = 1'b0;
          w_tdata_nxt  = frame_byte(w_head_sha, {CW{1'b0}});
          w_tid_nxt    = w_head_id;
          w_tlen_nxt   = w_head_len;
        end else begin
          w_tvalid_nxt = 1'b0;
          w_tlast_nxt  = 1'b0;
        end
      end
      ST_SEND: begin
        if (r_tvalid && tready) begin
          if (r_cnt == LAST_IDX) begin
            // Frame done: release the head; IDLE gives the one-cycle gap.
            w_pop        = 1'b1;
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_tdata_nxt = frame_byte(w_head_sha, w_cnt_inc);
            w_tlast_nxt = (w_cnt_inc == LAST_IDX);
          end
        end else begin
          w_tvalid_nxt = r_tvalid;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_tvalid_nxt = 1'b0;
        w_tlast_nxt  = 1'b0;
      end
    endcase
  end

  assign tvalid = r_tvalid;
  assign tlast  = r_tlast;
  assign tdata  = r_tdata;
  assign tid    = r_tid;
  assign tlen   = r_tlen;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_sha_digest_tx.sv
module tb_sha_digest_tx;
  localparam int DB    = 48;
  localparam int DW    = DB * 8;
  localparam int DEPTH = 4;
`ifdef SHA_DIGEST_TX_HEX_EN
  localparam int FL = 2 * DB + 1;
`else
  localparam int FL = DB;
`endif

  logic clk = 1'b0, rstn = 1'b0, ivalid = 1'b0, tready = 1'b1;
  logic [31:0] iid = 32'h0;
  logic [60:0] ilen = 61'h0;
  logic [DW-1:0] isha = '0;
  logic tvalid, tlast, ovf;
  logic [31:0] tid;
  logic [60:0] tlen;
  logic [7:0] tdata;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit rand_rdy = 1'b0, fix_rdy = 1'b1;

  // reference model: queue of accepted digests
  logic [31:0] q_id[$];
  logic [60:0] q_len[$];
  logic [DW-1:0] q_dig[$];
  int q_av[$];
  int idx = 0, end_cyc = -10, rise_cyc = -1;
  bit ovf_m = 1'b0, prev_stall = 1'b0, prev_tv = 1'b0;
  logic [7:0] p_data; logic p_last; logic [31:0] p_id; logic [60:0] p_len;
  logic [7:0] cap[$]; bit cap_last[$]; logic [31:0] cap_id[$]; logic [31:0] done_ids[$];

  sha_digest_tx #(.DIGEST_BYTES(DB), .FIFO_AW(2)) dut (
    .clk(clk), .rstn(rstn), .ivalid(ivalid), .iid(iid), .ilen(ilen), .isha(isha),
    .tvalid(tvalid), .tready(tready), .tlast(tlast), .tid(tid), .tlen(tlen),
    .tdata(tdata), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected frame byte i of digest d, straight from the frame format.
  function automatic logic [7:0] exp_byte(input logic [DW-1:0] d, input int i);
    logic [DW-1:0] t;
`ifdef SHA_DIGEST_TX_HEX_EN
    string hx = "0123456789abcdef";
    if (i == 2 * DB) return 8'h0A;
    t = d >> (4 * (2 * DB - 1 - i));
    return hx[t[3:0]];
`else
    t = d >> (8 * (DB - 1 - i));
    return t[7:0];
`endif
  endfunction

  function automatic logic [DW-1:0] rnd_dig();
    logic [DW-1:0] d;
    for (int b = 0; b < DW / 32; b++) d[b*32 +: 32] = $urandom();
    return d;
  endfunction

  // Per-cycle compare against the model, then advance the model for the coming edge.
  always @(negedge clk) begin : mon
    bit exp_tv;
    if (!rstn) begin
      chk("rst_tvalid", tvalid, 0); chk("rst_tlast", tlast, 0); chk("rst_tdata", tdata, 0);
      chk("rst_tid", tid, 0); chk("rst_tlen", tlen, 0); chk("rst_ovf", ovf, 0);
      q_id.delete(); q_len.delete(); q_dig.delete(); q_av.delete();
      idx = 0; ovf_m = 0; prev_stall = 0; prev_tv = 0; end_cyc = -10;
    end else begin
      exp_tv = (q_id.size() > 0) && (cyc >= q_av[0]) && (cyc != end_cyc + 1);
      chk("tvalid", tvalid, exp_tv);
      chk("ovf", ovf, ovf_m);
      if (prev_stall) begin
        chk("hold_tdata", tdata, p_data); chk("hold_tlast", tlast, p_last);
        chk("hold_tid", tid, p_id); chk("hold_tlen", tlen, p_len);
      end
      if (tvalid && q_id.size() > 0) begin
        chk("tdata", tdata, exp_byte(q_dig[0], idx));
        chk("tlast", tlast, idx == FL - 1);
        chk("tid", tid, q_id[0]);
        chk("tlen", tlen, q_len[0]);
      end
      if (tvalid && !prev_tv) rise_cyc = cyc;
      if (ivalid) begin
        if (q_id.size() < DEPTH) begin
          q_id.push_back(iid); q_len.push_back(ilen); q_dig.push_back(isha); q_av.push_back(cyc + 2);
        end else begin
          ovf_m = 1;
        end
      end
      if (tvalid && tready && q_id.size() > 0) begin
        cap.push_back(tdata); cap_last.push_back(tlast); cap_id.push_back(tid);
        idx++;
        if (idx == FL) begin
          done_ids.push_back(q_id[0]);
          void'(q_id.pop_front()); void'(q_len.pop_front());
          void'(q_dig.pop_front()); void'(q_av.pop_front());
          idx = 0; end_cyc = cyc;
        end
      end
      prev_stall = tvalid && !tready; prev_tv = tvalid;
      p_data = tdata; p_last = tlast; p_id = tid; p_len = tlen;
    end
    cyc++;
  end

  // Consumer ready: fixed level or random 50%.
  initial forever begin
    @(posedge clk); #1;
    tready = rand_rdy ? 1'($urandom_range(0, 1)) : fix_rdy;
  end

  task automatic drive(input bit v, input logic [31:0] id, input logic [60:0] ln, input logic [DW-1:0] dg);
    @(posedge clk); #1;
    ivalid = v; iid = id; ilen = ln; isha = dg;
  endtask

  task automatic wait_idle(input int bound);
    bit done = 0;
    for (int k = 0; k < bound && !done; k++) begin
      @(posedge clk); #1;
      if (q_id.size() == 0 && !tvalid) done = 1;
    end
    chk("drain_done", done, 1);
  endtask

  initial begin
    logic [DW-1:0] d;
    int pc, ones;
    bit ok;

    // reset held 4 cycles with tready=1
    rstn = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("lit_rst_tvalid", tvalid, 0); chk("lit_rst_ovf", ovf, 0); chk("lit_rst_tid", tid, 0);
    rstn = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_after_reset", tvalid, 0);

    // single frame, constant ready
    for (int i = 0; i < DB; i++) d[DW-1-8*i -: 8] = 8'(i);
`ifdef SHA_DIGEST_TX_HEX_EN
    d[DW-1 -: 8] = 8'hAB;
    d[7:0] = 8'h09;
`endif
    cap.delete(); cap_last.delete(); cap_id.delete();
    drive(1, 32'h111, 61'd3, d); pc = cyc;
    drive(0, 32'h0, 61'd0, '0);
    wait_idle(500);
    chk("first_latency", 64'(rise_cyc - pc), 2);
    chk("frame_len", cap.size(), FL);
    ones = 0;
    foreach (cap_last[i]) ones += int'(cap_last[i]);
    chk("tlast_count", ones, 1);
    if (cap.size() == FL) begin
      chk("tlast_pos", cap_last[FL-1], 1);
      chk("lit_tid", cap_id[FL-1], 32'h111);
`ifdef SHA_DIGEST_TX_HEX_EN
      chk("lit_hex0", cap[0], 8'h61); chk("lit_hex1", cap[1], 8'h62);
      chk("lit_hex94", cap[FL-3], 8'h30); chk("lit_hex95", cap[FL-2], 8'h39);
      chk("lit_hexnl", cap[FL-1], 8'h0A);
`else
      for (int i = 0; i < FL; i++) chk("lit_byte", cap[i], 64'(i));
`endif
    end

    // same frame under random backpressure
    rand_rdy = 1;
    cap.delete(); cap_last.delete(); cap_id.delete();
    drive(1, 32'h111, 61'd3, d);
    drive(0, 32'h0, 61'd0, '0);
    wait_idle(3000);
    rand_rdy = 0;
    chk("bp_len", cap.size(), FL);
    for (int i = 0; i < cap.size() && i < FL; i++) chk("bp_byte", cap[i], exp_byte(d, i));

    // fill FIFO with tready low, overflow on the fifth
    fix_rdy = 0;
    repeat (2) @(posedge clk);
    done_ids.delete();
    for (int k = 1; k <= 5; k++) drive(1, 32'(k * 32'h111), 61'(k), rnd_dig());
    drive(0, 32'h0, 61'd0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("lit_ovf_set", ovf, 1);
    chk("lit_stalled_tvalid", tvalid, 1);
    fix_rdy = 1;
    wait_idle(3000);
    chk("ovf_frames", done_ids.size(), 4);
    for (int k = 0; k < done_ids.size() && k < 4; k++) chk("ovf_order", done_ids[k], 32'((k + 1) * 32'h111));

    // reset mid-frame with two more entries queued
    cap.delete();
    for (int k = 0; k < 3; k++) drive(1, 32'hA0 + 32'(k), 61'd9, rnd_dig());
    drive(0, 32'h0, 61'd0, '0);
    ok = 0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(posedge clk); #1;
      if (cap.size() >= 10) ok = 1;
    end
    chk("reached_10_bytes", ok, 1);
    rstn = 0;
    #1;
    chk("lit_midrst_tvalid", tvalid, 0);
    chk("lit_midrst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    cap.delete();
    repeat (30) @(posedge clk);
    #1;
    chk("no_bytes_after_reset", cap.size(), 0);

    // random traffic with random backpressure
    rand_rdy = 1;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 12)) @(posedge clk);
      drive(1, $urandom(), 61'({$urandom(), $urandom()}), rnd_dig());
      drive(0, 32'h0, 61'd0, '0);
    end
    wait_idle(8000);
    rand_rdy = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sha_digest_tx.md
Name: sha_digest_tx

Overview:
Serializes digest results from the SHA cores (one-cycle ivalid pulse carrying id, length and digest) into a byte stream using the same valid/ready/last/id byte protocol the cores accept on their input side. It sits behind a sha256/sha384/sha512 core and feeds a UART, DMA or second-stage consumer. A small FIFO absorbs back-to-back digests because the core output has no backpressure.

Parameters:
DIGEST_BYTES, 48, digest size in bytes; legal values 28, 32, 48, 64. isha width = DIGEST_BYTES*8.
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries of {id, len, digest}.

Ports:
rstn  input  1  asynchronous active-low reset
clk  input  1  clock, all logic on rising edge
ivalid  input  1  digest valid, one-cycle pulse, no ready
iid  input  32  id of the hashed message
ilen  input  61  message length in bytes
isha  input  DIGEST_BYTES*8  digest; byte 0 = isha[MSB -: 8]
tvalid  output  1  output byte valid
tready  input  1  consumer ready
tlast  output  1  last byte of a frame
tid  output  32  id of the current frame, constant for the whole frame
tlen  output  61  ilen of the current frame, constant for the whole frame
tdata  output  8  output byte
ovf  output  1  sticky overflow flag

Behaviour:
- Clock is clk; reset is rstn, asynchronous, active-low. Asserting rstn=0 clears everything immediately: tvalid=0, tlast=0, tid=0, tlen=0, tdata=0, ovf=0, FIFO empty, FSM in IDLE. Any partially sent frame is discarded.
- FIFO write: ivalid=1 and FIFO not full -> entry written at that edge.
  - ivalid=1 while full -> entry dropped, ovf=1 from the next cycle until reset.
  - A pop on the same edge does not free space for that push; full is evaluated before the pop.
- The head entry stays in the FIFO until its tlast byte handshakes. Capacity is therefore 2**FIFO_AW digests, including the one being sent.
- FSM:
  - IDLE: FIFO non-empty -> load tid/tlen from the head, byte counter=0, present byte 0 (tvalid=1). Go to SEND.
  - SEND: on tvalid&tready:
    - If the counter is not at the last byte: counter+1 and present the next byte on the following cycle.
    - If it is the last byte: pop the FIFO, tvalid=0, go to IDLE.
- Latency: an ivalid pulse at cycle N into an empty, idle block gives tvalid=1 at cycle N+2.
- Between frames tvalid is low for exactly one cycle.
- All outputs are registered. While tvalid=1 and tready=0, tdata, tlast, tid and tlen hold stable; tvalid never drops without a handshake.
- Frame length (raw mode) is DIGEST_BYTES bytes, most significant byte first. tlast=1 only on the final byte.
- tready is ignored while tvalid=0.

Optional Feature:
SHA_DIGEST_TX_HEX_EN.
- Defined: each frame is the digest as lowercase ASCII hex.
  - High nibble first; nibble 0-9 maps to 0x30-0x39 and a-f maps to 0x61-0x66.
  - The hex characters are followed by one byte 0x0A carrying tlast.
  - Frame length is 2*DIGEST_BYTES+1 (97 for sha384).
- Undefined: raw binary frames as described above. No hex logic is synthesized.

Test Plan:
- Reset: hold rstn=0 for 4 cycles with tready=1 -> tvalid, tlast, tdata, tid, tlen and ovf all 0; no frame appears after release.
- Single frame: DIGEST_BYTES=48, iid=0x111, ilen=3, isha bytes 0x00..0x2F, tready=1 constantly -> tvalid rises 2 cycles after ivalid, then 48 consecutive bytes 0x00..0x2F. tlast is high only on 0x2F; tid=0x111 and tlen=3 for the whole frame.
- Backpressure: same input, tready random 50% -> identical byte sequence; tdata, tlast and tid stable during every stalled cycle; exactly 48 handshakes.
- FIFO fill and overflow: tready=0, five ivalid pulses with ids 0x111..0x555 -> ovf=1 after the fifth. Releasing tready=1 gives four frames in order 0x111..0x444, each followed by a one-cycle tvalid gap; 0x555 never appears.
- Reset mid-frame: assert rstn=0 after 10 bytes of a frame with two more entries queued -> tvalid=0 immediately. After release, no bytes are output until a new ivalid.
- Hex mode (SHA_DIGEST_TX_HEX_EN defined): isha byte 0 = 0xAB, byte 47 = 0x09 -> first bytes 0x61, 0x62. Final three bytes are 0x30, 0x39, 0x0A, with tlast on 0x0A. Total 97 handshakes.
